// File: rtl/fsmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsmc_pkg
// Description : Shared constants and types for the handshaked FSMC slave.
// Revision    : 1.0
// ============================================================================
package fsmc_pkg;

    localparam int c_IDX_IDLE     = 0;
    localparam int c_IDX_WR_HOLD  = 1;
    localparam int c_IDX_WR_END   = 2;
    localparam int c_IDX_RD_REQ   = 3;
    localparam int c_IDX_RD_DRIVE = 4;
    localparam int c_NUM_STATES   = 5;

    typedef enum logic [c_NUM_STATES-1:0] {
        ST_IDLE     = 5'b00001,
        ST_WR_HOLD  = 5'b00010,
        ST_WR_END   = 5'b00100,
        ST_RD_REQ   = 5'b01000,
        ST_RD_DRIVE = 5'b10000
    } state_t;

    localparam logic [15:0] c_TIMEOUT_DATA_DEFAULT = 16'hDEAD;
    localparam int          c_MIN_SYNC_STAGES      = 2;

    function automatic bit sync_stages_ok(input int stages);
        return stages >= c_MIN_SYNC_STAGES;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_bits_rst.sv
`default_nettype none
// ============================================================================
// Module      : sync_bits_rst
// Description : Multi-stage synchroniser whose flops reset to all-ones.
// Revision    : 1.0
// ============================================================================
module sync_bits_rst #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [STAGES-1:0][W-1:0] r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fsmc_hs_slave.sv
`default_nettype none
// ============================================================================
// Module      : fsmc_hs_slave
// Description : FSMC bus slave with valid/ack register handshakes and NWAIT.
// Revision    : 1.0
// ============================================================================
module fsmc_hs_slave
    import fsmc_pkg::*;
#(
    parameter int          ADRW         = 8,
    parameter int          DATW         = 16,
    parameter int          SYNC_STAGES  = 2,
    parameter int          RD_TIMEOUT   = 15,
    parameter logic [15:0] TIMEOUT_DATA = c_TIMEOUT_DATA_DEFAULT
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            aNE,
    input  logic            aNOE,
    input  logic            aNWE,
    input  logic [ADRW-1:0] aAn,
    input  logic [DATW-1:0] aDn,
    output logic            io_output,
    output logic [DATW-1:0] io_data,
    output logic            aNWAIT,
    output logic            rd_req,
    output logic [ADRW-1:0] rd_adr,
    input  logic            rd_ack,
    input  logic [DATW-1:0] rd_data,
    output logic            wr_valid,
    output logic [ADRW-1:0] wr_adr,
    output logic [DATW-1:0] wr_data,
    input  logic            wr_ready,
    output logic [7:0]      timeout_cnt
);

    localparam int              c_CW       = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [DATW-1:0] c_TO_DATA  = DATW'(TIMEOUT_DATA);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(RD_TIMEOUT - 1);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync_stages
        $error("fsmc_hs_slave: SYNC_STAGES must be at least %0d", c_MIN_SYNC_STAGES);
    end
    if (RD_TIMEOUT < 1) begin : g_bad_rd_timeout
        $error("fsmc_hs_slave: RD_TIMEOUT must be at least 1");
    end

    logic [2:0] w_sync;
    logic       w_sne;
    logic       w_snoe;
    logic       w_snwe;

    sync_bits_rst #(
        .W      (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .i_d  ({aNE, aNOE, aNWE}),
        .o_q  (w_sync)
    );

    assign w_sne  = w_sync[2];
    assign w_snoe = w_sync[1];
    assign w_snwe = w_sync[0];

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            rd_adr      <= '0;
            wr_adr      <= '0;
            wr_data     <= '0;
            io_data     <= '0;
            timeout_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Write wins when NOE and NWE are both low.
                    if (!w_sne && !w_snwe) begin
                        wr_adr  <= aAn;
                        wr_data <= aDn;
                        r_state <= ST_WR_HOLD;
                    end else if (!w_sne && !w_snoe) begin
                        rd_adr  <= aAn;
                        r_cnt   <= '0;
                        r_state <= ST_RD_REQ;
                    end
                end
                ST_WR_HOLD: begin
                    if (wr_ready) begin
                        r_state <= ST_WR_END;
                    end
                end
                ST_WR_END: begin
                    if (w_sne || w_snwe) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    // Host abort drops the read; an ack beats the terminal count.
                    if (w_sne || w_snoe) begin
                        r_state <= ST_IDLE;
                    end else if (rd_ack) begin
                        io_data <= rd_data;
                        r_state <= ST_RD_DRIVE;
                    end else if (r_cnt == c_CNT_LAST) begin
                        io_data <= c_TO_DATA;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        r_state <= ST_RD_DRIVE;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                ST_RD_DRIVE: begin
                    if (w_sne || w_snoe) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_req    = r_state[c_IDX_RD_REQ];
    assign wr_valid  = r_state[c_IDX_WR_HOLD];
    assign aNWAIT    = ~(rd_req | wr_valid);
    assign io_output = r_state[c_IDX_RD_DRIVE] & ~w_sne & ~w_snoe;

endmodule
`default_nettype wire

// File: tb/tb_fsmc_hs_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsmc_hs_slave
// Description : Self-checking bench for fsmc_hs_slave (tables, random, corners).
// Revision    : 1.0
// ============================================================================
module tb_fsmc_hs_slave;

    localparam int T = 15;

    logic        clk;
    logic        nrst;
    logic        aNE, aNOE, aNWE;
    logic [7:0]  aAn;
    logic [15:0] aDn;
    logic        io_output;
    logic [15:0] io_data;
    logic        aNWAIT;
    logic        rd_req;
    logic [7:0]  rd_adr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        wr_valid;
    logic [7:0]  wr_adr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [7:0]  timeout_cnt;

    fsmc_hs_slave #(
        .ADRW         (8),
        .DATW         (16),
        .SYNC_STAGES  (2),
        .RD_TIMEOUT   (T),
        .TIMEOUT_DATA (16'hDEAD)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .aNE         (aNE),
        .aNOE        (aNOE),
        .aNWE        (aNWE),
        .aAn         (aAn),
        .aDn         (aDn),
        .io_output   (io_output),
        .io_data     (io_data),
        .aNWAIT      (aNWAIT),
        .rd_req      (rd_req),
        .rd_adr      (rd_adr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_adr      (wr_adr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .timeout_cnt (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [7:0]  adr;
        logic [15:0] dat;
        int          dly;        // write: ready delay; read: ack delay in rd_req cycles
        int          rel;        // write: release NWE after this many wr_valid cycles (-1 = hold)
        int          exp_cycles; // wr_valid / rd_req high cycles
        logic [15:0] exp_data;
        int          exp_to;     // timeout_cnt after the transaction
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t v, input bit noe_too);
        int vcnt, wcnt, drv;
        bit seen, done, bad, rdseen, first_drive, first_nwait;
        vcnt = 0; wcnt = 0; drv = 0;
        seen = 0; done = 0; bad = 0; rdseen = 0; first_drive = 0; first_nwait = 0;
        aAn = v.adr;
        aNE = 1'b0;
        if (v.is_wr) begin
            aDn  = v.dat;
            aNWE = 1'b0;
            aNOE = noe_too ? 1'b0 : 1'b1;
            for (int c = 0; c < 200 && !done; c++) begin
                tick();
                if (rd_req) rdseen = 1;
                if (!aNWAIT) wcnt++;
                if (wr_valid) begin
                    if (wr_adr !== v.adr || wr_data !== v.dat) bad = 1;
                    wr_ready = (vcnt >= v.dly);
                    vcnt++;
                    aAn = ~v.adr;
                    aDn = ~v.dat;
                    if (v.rel >= 0 && vcnt >= v.rel) aNWE = 1'b1;
                    seen = 1;
                end else begin
                    wr_ready = 1'b0;
                    if (seen) done = 1;
                end
            end
            chk("wr_done", done, 1);
            chk("wr_valid_cycles", vcnt, v.exp_cycles);
            chk("wr_nwait_low_cycles", wcnt, v.exp_cycles);
            chk("wr_addr_data_stable", bad, 0);
            chk("wr_no_rd_req", rdseen, 0);
            chk("wr_timeout_cnt", timeout_cnt, v.exp_to);
            aNE = 1'b1; aNWE = 1'b1; aNOE = 1'b1;
            repeat (6) tick();
            chk("wr_idle_valid", wr_valid, 0);
            chk("wr_idle_nwait", aNWAIT, 1);
        end else begin
            aDn  = 16'($urandom);
            aNOE = 1'b0;
            aNWE = 1'b1;
            for (int c = 0; c < 200 && !done; c++) begin
                tick();
                if (!aNWAIT) wcnt++;
                if (rd_req) begin
                    if (rd_adr !== v.adr) bad = 1;
                    rd_ack  = (vcnt == v.dly);
                    rd_data = rd_ack ? v.dat : ~v.dat;
                    vcnt++;
                    seen = 1;
                end else begin
                    rd_ack  = 1'b0;
                    rd_data = 16'($urandom);
                    if (seen) begin
                        done        = 1;
                        first_drive = io_output;
                        first_nwait = aNWAIT;
                    end
                end
            end
            chk("rd_done", done, 1);
            chk("rd_req_cycles", vcnt, v.exp_cycles);
            chk("rd_nwait_low_cycles", wcnt, v.exp_cycles);
            chk("rd_addr", bad, 0);
            chk("rd_first_drive", first_drive, 1);
            chk("rd_nwait_after", first_nwait, 1);
            chk("rd_io_data", io_data, v.exp_data);
            chk("rd_timeout_cnt", timeout_cnt, v.exp_to);
            repeat (3) begin
                tick();
                if (io_output) drv++;
            end
            chk("rd_drive_hold", drv, 3);
            aNE = 1'b1; aNOE = 1'b1;
            repeat (4) tick();
            chk("rd_released_output", io_output, 0);
            chk("rd_io_data_kept", io_data, v.exp_data);
        end
    endtask

    vec_t tbl [8];

    initial begin
        int  tmodel;
        bit  seen, done, timedout;
        vec_t r;

        aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
        aAn = '0; aDn = '0;
        rd_ack = 1'b0; rd_data = '0; wr_ready = 1'b0;
        nrst = 1'b0;
        tmodel = 0;

        tbl[0] = '{1'b1, 8'd100, 16'h1234,  0, -1,  1, 16'h1234, 0};
        tbl[1] = '{1'b1, 8'h55,  16'hA5A5, 10,  3, 11, 16'hA5A5, 0};
        tbl[2] = '{1'b1, 8'h56,  16'h0F0F,  0, -1,  1, 16'h0F0F, 0};
        tbl[3] = '{1'b0, 8'h06,  16'hBEEF,  4, -1,  5, 16'hBEEF, 0};
        tbl[4] = '{1'b0, 8'h07,  16'h1111, 99, -1, 15, 16'hDEAD, 1};
        tbl[5] = '{1'b0, 8'h08,  16'h2222, 14, -1, 15, 16'h2222, 1};
        tbl[6] = '{1'b0, 8'h09,  16'h3333,  0, -1,  1, 16'h3333, 1};
        tbl[7] = '{1'b0, 8'h0A,  16'h4444, 15, -1, 15, 16'hDEAD, 2};

        repeat (3) tick();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_io_output", io_output, 0);
        chk("rst_nwait", aNWAIT, 1);
        chk("rst_addrs", {rd_adr, wr_adr}, 0);
        chk("rst_data", {wr_data, io_data}, 0);
        chk("rst_timeout_cnt", timeout_cnt, 0);
        nrst = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i], 1'b0);
            tmodel = tbl[i].exp_to;
        end

        for (int i = 0; i < 40; i++) begin
            r.is_wr = ($urandom_range(0, 1) == 1);
            r.adr   = 8'($urandom);
            r.dat   = 16'($urandom);
            r.rel   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : -1;
            if (r.is_wr) begin
                r.dly        = int'($urandom_range(0, 6));
                r.exp_cycles = r.dly + 1;
                r.exp_data   = r.dat;
            end else begin
                r.dly        = int'($urandom_range(0, 2 * T));
                timedout     = (r.dly >= T);
                r.exp_cycles = timedout ? T : r.dly + 1;
                r.exp_data   = timedout ? 16'hDEAD : r.dat;
                if (timedout && tmodel < 255) tmodel++;
            end
            r.exp_to = tmodel;
            run_txn(r, 1'b0);
        end

        // NOE and NWE low together: a write only
        r = '{1'b1, 8'h77, 16'hCAFE, 0, -1, 1, 16'hCAFE, tmodel};
        run_txn(r, 1'b1);

        for (int i = 0; i < 300; i++) begin
            if (tmodel < 255) tmodel++;
            r = '{1'b0, 8'(i), 16'h0BAD, 99, -1, T, 16'hDEAD, tmodel};
            run_txn(r, 1'b0);
        end
        chk("timeout_saturated", timeout_cnt, 255);

        // Reset pulsed while the pad is being driven
        aAn = 8'h21; aNE = 1'b0; aNOE = 1'b0;
        seen = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            tick();
            if (rd_req) begin
                rd_ack = 1'b1; rd_data = 16'h4321; seen = 1;
            end else begin
                rd_ack = 1'b0;
                if (seen) done = 1;
            end
        end
        chk("rstdrv_reached_drive", done, 1);
        chk("rstdrv_pre_output", io_output, 1);
        chk("rstdrv_pre_data", io_data, 16'h4321);
        #2 nrst = 1'b0;
        #1;
        chk("rstdrv_output", io_output, 0);
        chk("rstdrv_nwait", aNWAIT, 1);
        chk("rstdrv_rd_req", rd_req, 0);
        chk("rstdrv_io_data", io_data, 0);
        chk("rstdrv_timeout_cnt", timeout_cnt, 0);
        aNE = 1'b1; aNOE = 1'b1;
        repeat (3) tick();
        nrst = 1'b1;
        tmodel = 0;
        repeat (3) tick();
        r = '{1'b0, 8'h22, 16'h5678, 3, -1, 4, 16'h5678, 0};
        run_txn(r, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
